// File: rtl/inv_transcb_pkg.sv
// rtl/inv_transcb_pkg.sv - shared Cb skin-tone transform constants and LUT generators
package inv_transcb_pkg;

    localparam int TCB_W   = 10;
    localparam int SCL_W   = 12;
    localparam int FRAC    = 8;
    localparam int K_L     = 125;
    localparam int K_H     = 188;
    localparam int MEAN_KH = 108;

    // Chroma cluster width model: W_CB inside the band, tapering to WL/WH at Y_MIN/Y_MAX.
    localparam int W_CB      = 47;
    localparam int WL_CB     = 23;
    localparam int WH_CB     = 14;
    localparam int CB_EDGE   = 118;
    localparam int Y_MIN     = 16;
    localparam int Y_MAX     = 235;

    localparam int D_W = TCB_W + 1;
    localparam int P_W = TCB_W + SCL_W + 2;
    localparam int Q_W = P_W - FRAC;
    localparam int S_W = Q_W + 1;

    localparam int ROUND_HALF = 1 << (FRAC - 1);

    localparam logic [7:0] K_L_Y = 8'(K_L);
    localparam logic [7:0] K_H_Y = 8'(K_H);

    function automatic int clamp_y(input int y);
        if (y < Y_MIN) return Y_MIN;
        if (y > Y_MAX) return Y_MAX;
        return y;
    endfunction

    // Cb cluster centre versus luma, rounded half up.
    function automatic logic [7:0] cb_mean_f(input int y);
        int yc;
        int num;
        int den;
        yc = clamp_y(y);
        if (yc < K_L) begin
            num = (K_L - yc) * (CB_EDGE - MEAN_KH);
            den = K_L - Y_MIN;
        end else if (yc > K_H) begin
            num = (yc - K_H) * (CB_EDGE - MEAN_KH);
            den = Y_MAX - K_H;
        end else begin
            num = 0;
            den = 1;
        end
        return 8'(MEAN_KH + (2 * num + den) / (2 * den));
    endfunction

    // W(y)/W_CB in Q4.FRAC, rounded half up; exactly 1.0 inside the band.
    function automatic logic [SCL_W-1:0] inv_scale_f(input int y);
        int yc;
        int num;
        int den;
        yc = clamp_y(y);
        if (yc < K_L) begin
            num = WL_CB * (K_L - Y_MIN) + (yc - Y_MIN) * (W_CB - WL_CB);
            den = W_CB * (K_L - Y_MIN);
        end else if (yc > K_H) begin
            num = WH_CB * (Y_MAX - K_H) + (Y_MAX - yc) * (W_CB - WH_CB);
            den = W_CB * (Y_MAX - K_H);
        end else begin
            num = 1;
            den = 1;
        end
        return SCL_W'((num * (2 << FRAC) + den) / (2 * den));
    endfunction

endpackage

// File: rtl/inv_transcb_if.sv
// rtl/inv_transcb_if.sv - sample in / recovered Cb out handshake bundle
interface inv_transcb_if;
    import inv_transcb_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [7:0]              y;
    logic signed [TCB_W-1:0] tcb;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              cb;

    modport slave (
        input  in_valid, y, tcb, out_ready,
        output in_ready, out_valid, cb
    );

    modport master (
        output in_valid, y, tcb, out_ready,
        input  in_ready, out_valid, cb
    );

endinterface

// File: rtl/inv_transcb_lut.sv
// rtl/inv_transcb_lut.sv - combinational 256-entry ROM of the inverse width scale
module inv_widthcb_lut
    import inv_transcb_pkg::*;
(
    input  logic [7:0]       y,
    output logic [SCL_W-1:0] scl
);

    logic [SCL_W-1:0] rom [256];

    for (genvar i = 0; i < 256; i++) begin : g_rom
        assign rom[i] = inv_scale_f(i);
    end

    assign scl = rom[y];

endmodule

// File: rtl/inv_transcb.sv
// rtl/inv_transcb.sv - 5-stage inverse Cb skin-tone transform with valid/ready flow
module inv_transcb
    import inv_transcb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    inv_transcb_if.slave bus
);

    logic                    adv;
    logic                    v1, v2, v3, v4;
    logic [7:0]              y1;
    logic signed [TCB_W-1:0] t1, t2, t3, t4;
    logic                    pass2, pass3, pass4;
    logic [7:0]              mean2, mean3, mean4;
    logic [SCL_W-1:0]        scl2, scl3;
    logic signed [D_W-1:0]   d3;
    logic signed [Q_W-1:0]   q4;

    logic [7:0]              mean_rom [256];
    logic [SCL_W-1:0]        scl_lut;
    logic signed [P_W-1:0]   p_mul;
    logic signed [P_W-1:0]   p_rnd;
    logic signed [S_W-1:0]   s5;
    logic [7:0]              cb_sat;

    localparam logic signed [D_W-1:0] MEAN_KH_D = D_W'(MEAN_KH);

    // Whole pipeline moves as one unit, so an emit and an accept can share a cycle.
    assign adv          = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = adv;

    for (genvar i = 0; i < 256; i++) begin : g_mean
        assign mean_rom[i] = cb_mean_f(i);
    end

    inv_widthcb_lut u_scl_lut (
        .y   (y1),
        .scl (scl_lut)
    );

    assign p_mul = P_W'(d3) * P_W'($signed({1'b0, scl3}));
    assign p_rnd = p_mul + P_W'(ROUND_HALF);

    always_comb begin
        s5     = S_W'(t4);
        cb_sat = '0;
        if (!pass4) begin
            s5 = S_W'(q4) + S_W'($signed({1'b0, mean4}));
        end
        if (s5 < 0) begin
            cb_sat = 8'h00;
        end else if (s5 > 255) begin
            cb_sat = 8'hFF;
        end else begin
            cb_sat = s5[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            v3            <= 1'b0;
            v4            <= 1'b0;
            y1            <= '0;
            t1            <= '0;
            t2            <= '0;
            t3            <= '0;
            t4            <= '0;
            pass2         <= 1'b0;
            pass3         <= 1'b0;
            pass4         <= 1'b0;
            mean2         <= '0;
            mean3         <= '0;
            mean4         <= '0;
            scl2          <= '0;
            scl3          <= '0;
            d3            <= '0;
            q4            <= '0;
            bus.out_valid <= 1'b0;
            bus.cb        <= '0;
        end else if (adv) begin
            v1            <= bus.in_valid;
            y1            <= bus.y;
            t1            <= bus.tcb;

            // Band test uses y1 of this same sample, never a neighbouring stage.
            v2            <= v1;
            pass2         <= (y1 >= K_L_Y) && (y1 <= K_H_Y);
            mean2         <= mean_rom[y1];
            scl2          <= scl_lut;
            t2            <= t1;

            v3            <= v2;
            pass3         <= pass2;
            mean3         <= mean2;
            scl3          <= scl2;
            t3            <= t2;
            d3            <= D_W'(t2) - MEAN_KH_D;

            v4            <= v3;
            pass4         <= pass3;
            mean4         <= mean3;
            t4            <= t3;
            q4            <= Q_W'(p_rnd >>> FRAC);

            bus.out_valid <= v4;
            bus.cb        <= cb_sat;
        end
    end

endmodule

// File: tb/tb_inv_transcb.sv
// tb/tb_inv_transcb.sv - randomized self-checking bench for inv_transcb
module tb_inv_transcb;
    import inv_transcb_pkg::TCB_W;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    bit   bp_rand;
    int   obs_q[$];

    inv_transcb_if bus ();

    inv_transcb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) obs_q.push_back(int'(bus.cb));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Piecewise-linear interpolation scaled by s/d, rounded half up (all terms positive).
    function automatic int interp_round(input int x0, input int v0, input int x1, input int v1,
                                        input int x, input int s, input int d);
        int dx;
        int num;
        dx  = x1 - x0;
        num = v0 * dx + (x - x0) * (v1 - v0);
        return (2 * s * num + d * dx) / (2 * d * dx);
    endfunction

    function automatic int ref_mean(input int y);
        int yc;
        yc = (y < 16) ? 16 : ((y > 235) ? 235 : y);
        if (yc < 125) return interp_round(16, 118, 125, 108, yc, 1, 1);
        if (yc > 188) return interp_round(188, 108, 235, 118, yc, 1, 1);
        return 108;
    endfunction

    function automatic int ref_scale(input int y);
        int yc;
        yc = (y < 16) ? 16 : ((y > 235) ? 235 : y);
        if (yc < 125) return interp_round(16, 23, 125, 47, yc, 256, 47);
        if (yc > 188) return interp_round(188, 47, 235, 14, yc, 256, 47);
        return 256;
    endfunction

    function automatic int ref_cb(input int y, input int tcb);
        int p;
        int s;
        if (y >= 125 && y <= 188) begin
            s = tcb;
        end else begin
            p = (tcb - 108) * ref_scale(y);
            s = int'($floor((real'(p) + 128.0) / 256.0)) + ref_mean(y);
        end
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input int yy, input int tt, output bit ok);
        bit acc;
        bus.in_valid = 1'b1;
        bus.y        = 8'(yy);
        bus.tcb      = TCB_W'(tt);
        ok = 1'b0;
        for (int b = 0; b < 100; b++) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n, input int base, output bit ok);
        ok = 1'b0;
        for (int b = 0; b < 6000; b++) begin
            if (obs_q.size() >= base + n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.y = '0;
        bus.tcb = '0;
        bp_rand = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_tests++;
        if (bus.cb !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cb: got %0d want 0", bus.cb);
        end
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        tick();
    endtask

    task automatic test_pass_band();
        int ys[3] = '{150, 125, 188};
        int ts[3] = '{90, -3, 300};
        int ex[3] = '{90, 0, 255};
        int lat;
        bit acc;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.y        = 8'(ys[k]);
            bus.tcb      = TCB_W'(ts[k]);
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            bus.in_valid = 1'b0;
            lat = 1;
            while (lat < 20) begin
                @(negedge clk);
                if (bus.out_valid) break;
                tick();
                lat++;
            end
            n_tests++;
            if (!acc || lat != 5) begin
                n_fail++;
                $display("FAIL pass_latency[%0d]: got %0d cycles (accepted=%b) want 5", k, lat, acc);
            end
            n_tests++;
            if (int'(bus.cb) !== ex[k]) begin
                n_fail++;
                $display("FAIL pass_cb[%0d]: y=%0d tcb=%0d got %0d want %0d", k, ys[k], ts[k], bus.cb, ex[k]);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_out_of_band();
        int ys[2] = '{124, 189};
        int exp_q[$];
        int base;
        int got;
        bit ok;
        bit all_ok;
        bp_rand = 1'b1;
        base = obs_q.size();
        all_ok = 1'b1;
        foreach (ys[k]) begin
            for (int t = -512; t <= 511; t++) begin
                if ($urandom_range(0, 7) == 0) tick();
                send(ys[k], t, ok);
                all_ok &= ok;
                exp_q.push_back(ref_cb(ys[k], t));
            end
        end
        wait_out(exp_q.size(), base, ok);
        bp_rand = 1'b0;
        bus.out_ready = 1'b1;
        n_tests++;
        if (!(all_ok && ok)) begin
            n_fail++;
            $display("FAIL oob_flow: got %0d outputs want %0d", obs_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (base + i < obs_q.size()) ? obs_q[base + i] : -1;
            n_tests++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL oob_cb[%0d]: got %0d want %0d", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_round_trip();
        int ys[5] = '{16, 60, 124, 189, 235};
        int exp_q[$];
        int base;
        int got;
        int tp;
        int diff;
        bit ok;
        bit all_ok;
        bp_rand = 1'b1;
        base = obs_q.size();
        all_ok = 1'b1;
        foreach (ys[k]) begin
            for (int c = 0; c < 256; c++) begin
                tp = int'($floor(real'(c - ref_mean(ys[k])) * 256.0 / real'(ref_scale(ys[k])) + 0.5)) + 108;
                if (tp >= -512 && tp <= 511) begin
                    send(ys[k], tp, ok);
                    all_ok &= ok;
                    exp_q.push_back(c);
                end
            end
        end
        wait_out(exp_q.size(), base, ok);
        bp_rand = 1'b0;
        bus.out_ready = 1'b1;
        n_tests++;
        if (!(all_ok && ok)) begin
            n_fail++;
            $display("FAIL rt_flow: got %0d outputs want %0d", obs_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (base + i < obs_q.size()) ? obs_q[base + i] : -1000;
            diff = got - exp_q[i];
            n_tests++;
            if (diff > 1 || diff < -1) begin
                n_fail++;
                $display("FAIL round_trip[%0d]: got %0d want %0d +/-1", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int ys[20];
        int ts[20];
        int base;
        int held;
        int got;
        bit ok;
        bit all_ok;
        bp_rand = 1'b0;
        bus.out_ready = 1'b1;
        base = obs_q.size();
        all_ok = 1'b1;
        held = 0;
        for (int i = 0; i < 20; i++) begin
            ys[i] = $urandom_range(0, 255);
            ts[i] = $urandom_range(0, 1023) - 512;
        end
        for (int i = 0; i < 10; i++) begin
            send(ys[i], ts[i], ok);
            all_ok &= ok;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.y         = 8'(ys[10]);
        bus.tcb       = TCB_W'(ts[10]);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_flags[%0d]: in_ready=%b out_valid=%b want 0/1", c, bus.in_ready, bus.out_valid);
            end
            if (c == 0) begin
                held = int'(bus.cb);
            end else begin
                n_tests++;
                if (int'(bus.cb) !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold[%0d]: got %0d want %0d", c, bus.cb, held);
                end
            end
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 10; i < 20; i++) begin
            send(ys[i], ts[i], ok);
            all_ok &= ok;
        end
        wait_out(20, base, ok);
        repeat (8) tick();
        n_tests++;
        if (!(all_ok && ok) || obs_q.size() - base != 20) begin
            n_fail++;
            $display("FAIL bp_count: got %0d outputs want 20", obs_q.size() - base);
        end
        for (int i = 0; i < 20; i++) begin
            got = (base + i < obs_q.size()) ? obs_q[base + i] : -1;
            n_tests++;
            if (got !== ref_cb(ys[i], ts[i])) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got %0d want %0d", i, got, ref_cb(ys[i], ts[i]));
            end
        end
    endtask

    task automatic test_bubbles();
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit ov[10];
        bit want;
        bp_rand = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            bus.in_valid = (t < 4) ? pat[t] : 1'b0;
            bus.y        = 8'(30 + t);
            bus.tcb      = TCB_W'(t * 7);
            @(negedge clk);
            ov[t] = bus.out_valid;
        end
        bus.in_valid = 1'b0;
        for (int t = 0; t < 10; t++) begin
            want = (t >= 5 && t < 9) ? pat[t - 5] : 1'b0;
            n_tests++;
            if (ov[t] !== want) begin
                n_fail++;
                $display("FAIL bubble[%0d]: out_valid got %b want %b", t, ov[t], want);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int base;
        int lat;
        bit ok;
        bit acc;
        bp_rand = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(200, 20 * i, ok);
        n_tests++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: out_valid got %b want 1", bus.out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.cb !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: out_valid=%b cb=%0d want 0/0", bus.out_valid, bus.cb);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        base = obs_q.size();
        bus.in_valid = 1'b1;
        bus.y        = 8'd10;
        bus.tcb      = TCB_W'(-100);
        @(negedge clk);
        acc = bus.in_ready;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (bus.out_valid) break;
            tick();
            lat++;
        end
        n_tests++;
        if (!acc || lat != 5) begin
            n_fail++;
            $display("FAIL midrst_latency: got %0d cycles (accepted=%b) want 5", lat, acc);
        end
        repeat (8) tick();
        n_tests++;
        if (obs_q.size() - base != 1) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d outputs want 1", obs_q.size() - base);
        end else if (obs_q[base] !== ref_cb(10, -100)) begin
            n_fail++;
            $display("FAIL midrst_cb: got %0d want %0d", obs_q[base], ref_cb(10, -100));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_pass_band();
        test_bubbles();
        test_backpressure();
        test_out_of_band();
        test_round_trip();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
